// File: rtl/mau_pkg.sv
// Shared types and constants for the 4-bit MAU command sequencer.
// Holds operand/accumulator widths, opcode and sequencer state encodings.
package mau_pkg;

    localparam int DW    = 4;
    localparam int ACC_W = 2 * DW;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_MUL  = 3'b011,
        OP_MAC  = 3'b100,
        OP_CLR  = 3'b101
    } mau_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

endpackage

// File: rtl/mau_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, LSB first.
// start clears the product; done flags the step that consumes the MSB.
module mau_shift_add_mul #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   prod,
    output logic             done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Next product/counter: clear on start, accumulate a<<cnt when b[cnt] is set.
    always_comb begin
        prod_d = prod_q;
        cnt_d  = cnt_q;
        if (start) begin
            prod_d = '0;
            cnt_d  = '0;
        end else if (step) begin
            if (b[cnt_q]) begin
                prod_d = prod_q + ({{W{1'b0}}, a} << cnt_q);
            end else begin
                prod_d = prod_q;
            end
            cnt_d = cnt_q + CW'(1);
        end else begin
            prod_d = prod_q;
            cnt_d  = cnt_q;
        end
    end

    // Product and bit-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

    assign prod = prod_q;
    assign done = step && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mau_op_sequencer.sv
// MAU command sequencer: FSM, accumulator, sticky overflow and handshakes.
// Build option MAU_SAT_EN: ADD/MAC saturate to all-ones on carry instead of wrapping.
module mau_op_sequencer #(
    parameter int DW = mau_pkg::DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DW-1:0]     cmd_a,
    input  logic [DW-1:0]     cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*DW-1:0]   res_data,
    output logic              ovf,
    output logic              busy
);

    import mau_pkg::*;

    localparam int AW = 2 * DW;
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_WB   = ST_WB;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          res_valid_q, res_valid_d;
    logic [AW-1:0] res_data_q, res_data_d;

    logic          mul_start, mul_step, mul_done;
    logic [AW-1:0] prod;
    logic [AW-1:0] addend;
    logic [AW:0]   sum;
    logic          carry;
    logic [AW-1:0] acc_sum;

    mau_shift_add_mul #(.W(DW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .step  (mul_step),
        .a     (a_q),
        .b     (b_q),
        .prod  (prod),
        .done  (mul_done)
    );

    assign addend = (op_q == OP_MAC) ? prod : {{DW{1'b0}}, a_q};
    assign sum    = {1'b0, acc_q} + {1'b0, addend};
    assign carry  = sum[AW];
`ifdef MAU_SAT_EN
    assign acc_sum = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
    assign acc_sum = sum[AW-1:0];
`endif

    // Sequencer next-state, operand latch and write-back datapath.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        mul_start   = 1'b0;
        mul_step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if ((cmd_op == OP_MUL) || (cmd_op == OP_MAC)) begin
                        state_d   = S_MUL;
                        mul_start = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_WB: begin
                state_d     = S_DONE;
                res_valid_d = 1'b1;
                case (op_q)
                    OP_LOAD: begin
                        acc_d = {{DW{1'b0}}, a_q};
                        ovf_d = 1'b0;
                    end
                    OP_CLR: begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                    OP_ADD, OP_MAC: begin
                        acc_d = acc_sum;
                        ovf_d = ovf_q | carry;
                    end
                    default: begin
                        acc_d = acc_q;
                        ovf_d = ovf_q;
                    end
                endcase
                res_data_d = (op_q == OP_MUL) ? prod : acc_d;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Ready is forced low while reset is asserted, not just after the next edge.
    assign cmd_ready = rst_n && ena && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mau_op_sequencer.sv
// Self-checking bench for mau_op_sequencer: directed scenarios plus random
// command streams compared against an arithmetic accumulator model.
module tb_mau_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, ena, cmd_valid, cmd_ready, res_valid, res_ready, ovf, busy;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic [7:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_acc;
    logic       m_ovf;

    mau_op_sequencer #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: accumulator semantics computed with plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] d, output int lat);
        int s;
        lat = (op == 3'd3 || op == 3'd4) ? 5 : 1;
        s = -1;
        case (op)
            3'd1: begin m_acc = {4'h0, a}; m_ovf = 1'b0; end
            3'd2: s = int'(m_acc) + int'(a);
            3'd4: s = int'(m_acc) + int'(a) * int'(b);
            3'd5: begin m_acc = 8'h00; m_ovf = 1'b0; end
            default: ;
        endcase
        if (s > 255) begin
            m_ovf = 1'b1;
`ifdef MAU_SAT_EN
            m_acc = 8'hFF;
`else
            m_acc = 8'(s - 256);
`endif
        end else if (s >= 0) begin
            m_acc = 8'(s);
        end
        d = (op == 3'd3) ? 8'(int'(a) * int'(b)) : m_acc;
    endtask

    // Issue one command, measure latency, hold in DONE for 'hold' cycles, then accept.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input bit drop_ena, input int hold,
                           output int lat, output logic [7:0] data, output logic ovf_o,
                           output bit hs_ok);
        int guard = 0;
        hs_ok = 1'b1;
        lat   = -1;
        data  = 8'hxx;
        ovf_o = 1'bx;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        if (drop_ena) ena = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
            @(posedge clk); #1;
            if (res_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) begin
            data  = res_data;
            ovf_o = ovf;
            for (int h = 0; h < hold; h++) begin
                if (res_data !== data || res_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0)
                    hs_ok = 1'b0;
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'd5; cmd_a = 4'hF; cmd_b = 4'hF;
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            if (res_data !== data || ovf !== ovf_o) hs_ok = 1'b0;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            if (res_valid !== 1'b0 || busy !== 1'b0) hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = 3'd0; cmd_a = 4'h0; cmd_b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({cmd_ready, res_valid, ovf, busy} !== 4'b0000 || res_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b vld=%b ovf=%b busy=%b data=%h, expected all 0",
                     cmd_ready, res_valid, ovf, busy, res_data);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        m_acc = 8'h00; m_ovf = 1'b0;
    endtask

    // Test-plan sequence: LOAD/MUL/NOP, then MAC twice into overflow, then CLR.
    task automatic test_directed();
        logic [2:0] ops[8] = '{3'd1, 3'd3, 3'd0, 3'd1, 3'd4, 3'd4, 3'd5, 3'd7};
        logic [3:0] as[8]  = '{4'd5, 4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd9};
        logic [3:0] bs[8]  = '{4'd0, 4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd9};
        int lat, elat; logic [7:0] d, ed; logic o; bit hs;
        for (int k = 0; k < 8; k++) begin
            run_cmd(ops[k], as[k], bs[k], 1'b0, 0, lat, d, o, hs);
            model(ops[k], as[k], bs[k], ed, elat);
            n_tests += 4;
            if (lat !== elat) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", k, lat, elat); end
            if (d !== ed) begin n_fail++; $display("FAIL dir_data[%0d]: got %h expected %h", k, d, ed); end
            if (o !== m_ovf) begin n_fail++; $display("FAIL dir_ovf[%0d]: got %b expected %b", k, o, m_ovf); end
            if (!hs) begin n_fail++; $display("FAIL dir_handshake[%0d]: busy/ready/valid protocol violated", k); end
        end
    endtask

    // Result held 10 cycles with ignored command pulses; NOP afterwards shows acc intact.
    task automatic test_stall();
        logic [2:0] ops[2] = '{3'd2, 3'd0};
        int lat, elat; logic [7:0] d, ed; logic o; bit hs;
        for (int k = 0; k < 2; k++) begin
            run_cmd(ops[k], 4'd6, 4'd2, 1'b0, (k == 0) ? 10 : 0, lat, d, o, hs);
            model(ops[k], 4'd6, 4'd2, ed, elat);
            n_tests += 4;
            if (lat !== elat) begin n_fail++; $display("FAIL stall_latency[%0d]: got %0d expected %0d", k, lat, elat); end
            if (d !== ed) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", k, d, ed); end
            if (o !== m_ovf) begin n_fail++; $display("FAIL stall_ovf[%0d]: got %b expected %b", k, o, m_ovf); end
            if (!hs) begin n_fail++; $display("FAIL stall_hold[%0d]: result not stable or pulses not ignored", k); end
        end
    endtask

    task automatic test_ena_drop();
        int lat, elat; logic [7:0] d, ed; logic o; bit hs;
        run_cmd(3'd3, 4'd3, 4'd7, 1'b1, 2, lat, d, o, hs);
        model(3'd3, 4'd3, 4'd7, ed, elat);
        n_tests += 3;
        if (lat !== elat) begin n_fail++; $display("FAIL ena_latency: got %0d expected %0d", lat, elat); end
        if (d !== ed) begin n_fail++; $display("FAIL ena_data: got %h expected %h", d, ed); end
        if (!hs) begin n_fail++; $display("FAIL ena_handshake: protocol violated with ena low"); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ena_ready_low: got %b expected 0", cmd_ready); end
        ena = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ena_ready_back: got %b expected 1", cmd_ready); end
    endtask

    // Reset two cycles into a MAC that would overflow; afterwards NOP must read zero.
    task automatic test_reset_mid();
        int lat, elat; logic [7:0] d, ed; logic o; bit hs;
        int guard = 0;
        logic [2:0] ops[3] = '{3'd1, 3'd4, 3'd4};
        for (int k = 0; k < 3; k++) begin
            run_cmd(ops[k], 4'd15, 4'd15, 1'b0, 0, lat, d, o, hs);
            model(ops[k], 4'd15, 4'd15, ed, elat);
            n_tests++;
            if (d !== ed || o !== m_ovf || lat !== elat || !hs) begin
                n_fail++;
                $display("FAIL rmid_prep[%0d]: data %h ovf %b lat %0d, expected %h %b %0d", k, d, o, lat, ed, m_ovf, elat);
            end
        end
        while (cmd_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 4'd15; cmd_b = 4'd15;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, res_valid, ovf, busy} !== 4'b0000 || res_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rmid_async: rdy=%b vld=%b ovf=%b busy=%b data=%h, expected all 0",
                     cmd_ready, res_valid, ovf, busy, res_data);
        end
        m_acc = 8'h00; m_ovf = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        run_cmd(3'd0, 4'd0, 4'd0, 1'b0, 0, lat, d, o, hs);
        model(3'd0, 4'd0, 4'd0, ed, elat);
        n_tests += 2;
        if (d !== ed) begin n_fail++; $display("FAIL rmid_nop_data: got %h expected %h", d, ed); end
        if (o !== m_ovf || lat !== elat) begin n_fail++; $display("FAIL rmid_nop_ovf_lat: ovf %b lat %0d expected %b %0d", o, lat, m_ovf, elat); end
    endtask

    task automatic test_random();
        int lat, elat; logic [7:0] d, ed; logic o; bit hs;
        logic [2:0] op; logic [3:0] a, b;
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            if (k % 7 == 0) op = 3'd4;
            a  = 4'($urandom); b = 4'($urandom);
            run_cmd(op, a, b, 1'b0, $urandom_range(0, 3), lat, d, o, hs);
            model(op, a, b, ed, elat);
            n_tests += 4;
            if (lat !== elat) begin n_fail++; $display("FAIL rnd_latency[%0d] op%0d: got %0d expected %0d", k, op, lat, elat); end
            if (d !== ed) begin n_fail++; $display("FAIL rnd_data[%0d] op%0d a%0d b%0d: got %h expected %h", k, op, a, b, d, ed); end
            if (o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] op%0d: got %b expected %b", k, op, o, m_ovf); end
            if (!hs) begin n_fail++; $display("FAIL rnd_handshake[%0d] op%0d: protocol violated", k, op); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_ena_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mau_op_sequencer.md
# mau_op_sequencer

Command sequencer for the 4-bit multiply-accumulate unit (MAU) in the `tt_um_mau_top_4b` design. It accepts one command at a time over a valid/ready handshake and runs single-cycle ops (LOAD/ADD/CLR/NOP) or a 4-step iterative shift-add multiply (MUL/MAC). It owns the 8-bit accumulator and presents each result on a valid/ready output port. It sits between the pin-level decode of `ui_in`/`uio_in` and the `uo_out` result mux.

## Interface
Parameters:
- `DW`, 4: operand width; the accumulator and product are `2*DW` wide.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: design-selected; when low, no new command is accepted.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: equals `state==IDLE && ena`.
- `cmd_op` in 3: opcode. 000 NOP, 001 LOAD, 010 ADD, 011 MUL, 100 MAC, 101 CLR; 110/111 reserved and executed as NOP.
- `cmd_a`, `cmd_b` in DW: unsigned operands.
- `res_valid` out 1: result held; stays high until accepted.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 2*DW: result.
- `ovf` out 1: sticky overflow flag.
- `busy` out 1: `state != IDLE`.

## Operation
- States: IDLE, MUL, WB, DONE.
- IDLE: on `cmd_valid && cmd_ready`, latch the opcode and operands. MUL/MAC go to MUL with `cnt`=0 and `prod`=0. All other opcodes go to WB.
- MUL: each cycle, if `b[cnt]` then `prod += a << cnt`, then `cnt++`. After processing `cnt`=3, go to WB. The product is exact: the maximum is 15*15=225, with no overflow.
- WB (one cycle), then go to DONE:
  - LOAD: acc = {0,a}; ovf cleared.
  - CLR: acc = 0; ovf cleared.
  - ADD: acc = acc + a.
  - MAC: acc = acc + prod.
  - MUL and NOP: acc unchanged.
- `res_data` is captured in WB: `prod` for MUL, the new acc for every other opcode.
- Overflow applies to ADD and MAC: the carry out of the 8-bit sum sets `ovf`. Clamp or wrap behaviour is set by the Configuration section.
- DONE: `res_valid`=1 and `res_data` stable. On `res_ready`, go to IDLE.
- `ena` falling mid-operation does not abort; the operation completes and waits in DONE.

## Timing
- Reset values: `cmd_ready`=0 during reset (becomes 1 once `rst_n` and `ena` are high), `res_valid`=0, `res_data`=0, `ovf`=0, `busy`=0, acc=0, state=IDLE.
- Latency, counted from the accept edge N to the edge where `res_valid` rises:
  - Single-cycle ops: 1 (N+1).
  - MUL/MAC: 5 (N+1..N+4 process bits 0..3, N+5 is WB).
- Accept from DONE back to IDLE takes one edge. The next command can be accepted at the following edge, so minimum command spacing is 3 cycles for single-cycle ops and 7 cycles for MUL/MAC.
- The `cmd_*` inputs are ignored outside IDLE. `res_ready` is ignored outside DONE.
- Asserting `rst_n` low at any point forces the reset values immediately. An in-flight result is discarded.

## Configuration
- `MAU_SAT_EN` defined: on ADD/MAC carry-out, acc clamps to 0xFF and `ovf` sets.
- `MAU_SAT_EN` undefined: acc wraps modulo 256 and `ovf` still sets.
- Every other behaviour is identical in both builds.

## Structure
- `mau_pkg` holds:
  - `DW`
  - the opcode enum `mau_op_e` with the values above
  - the state enum `mau_state_e`
  - the `ACC_W` constant = 2*DW
- Sub-module `mau_shift_add_mul` contains `prod`, `cnt`, and the per-cycle add-shift step, with `start`/`step`/`done` controls. The sequencer holds the FSM, acc, `ovf`, and the handshakes.

## Test plan
- Reset, then LOAD a=5 → `res_valid` at N+1 with `res_data`=0x05 and `ovf`=0. `cmd_ready` is low while `busy`.
- MUL a=15 b=15 → `res_data`=0xE1 at N+5. A following NOP returns 0x05, confirming acc is unchanged.
- LOAD 0, then MAC 15×15, then MAC 15×15:
  - Without `MAU_SAT_EN`: results 0xE1, then 0xC2 with `ovf`=1.
  - With `MAU_SAT_EN`: results 0xE1, then 0xFF with `ovf`=1.
  - A following CLR clears `ovf`.
- `res_ready` held low for 10 cycles in DONE → `res_data` is stable. `cmd_valid` pulses are ignored, and acc is untouched.
- Set `ena`=0 during MUL a=3 b=7 → the result 0x15 still arrives at N+5. `cmd_ready` stays 0 until `ena` returns.
- Drop `rst_n` at cycle N+2 of a MAC → all outputs reset immediately. After release, NOP returns 0x00.
